cache_axi_rdmst: RTL and testbench
==================================

Name: cache_axi_rdmst

Overview:
- Memory-side read master serving the input cache's burst interface (rreq/rack/radr/rdata).
- Converts each cache refill request into one AXI4 INCR read burst of NTFR beats of 64 bits.
- Returns the beats to the cache as rack strobes with 64-bit rdata.
- Sits between the input cache and the accelerator's AXI read port; one cache client, one outstanding burst.

Parameters:
- NTFR, 64, beats per burst (8 B each); power of 2, 2..256; burst bytes = NTFR*8.
- AW, 32, AXI address width.

Ports:
- clk  in  1  clock
- xrst  in  1  asynchronous active-low reset
- base_adr  in  AW  tensor base byte address; must be NTFR*8 aligned; sampled on request accept
- rreq  in  1  cache refill request; level, held until first rack
- radr  in  24  burst start byte offset from the cache
- rack  out  1  beat strobe; rdata is valid in the same cycle
- rdata  out  64  beat data (uint8 x8, byte 0 in [7:0])
- m_araddr  out  AW  AXI read address
- m_arlen  out  8  AXI burst length
- m_arsize  out  3  AXI beat size
- m_arburst  out  2  AXI burst type
- m_arvalid  out  1  AXI read-address valid
- m_arready  in  1  AXI read-address ready
- m_rdata  in  64  AXI read data
- m_rresp  in  2  AXI read response
- m_rlast  in  1  AXI last beat
- m_rvalid  in  1  AXI read-data valid
- m_rready  out  1  AXI read-data ready
- err  out  1  sticky protocol/response error (see Optional Feature)

Behaviour:
- Reset (xrst=0, async): state=Idle; m_arvalid=0, m_rready=0, rack=0, rdata=0, m_araddr=0, err=0, beat counter=0.
- Constant outputs: m_arlen=NTFR-1, m_arsize=3'b011, m_arburst=2'b01 (INCR).
- FSM states: Idle, Addr, Data.
- Idle:
  - if rreq=1: m_araddr <= base_adr + {radr[23:log2(NTFR*8)], zeros}; low offset bits of radr are forced to 0.
  - m_arvalid <= 1; beat counter <= 0; go to Addr.
- Addr:
  - hold m_arvalid and m_araddr stable until m_arvalid && m_arready; then m_arvalid <= 0, m_rready <= 1, go to Data.
  - No AR retraction and no address change while waiting.
- Data:
  - m_rready stays 1; the cache never back-pressures.
  - Each cycle with m_rvalid=1: rack <= 1, rdata <= m_rdata, count <= count+1. Otherwise rack <= 0 and rdata holds.
  - Latency: AXI beat handshake at edge n gives rack=1 during cycle n+1 (one register stage).
  - On the beat where count == NTFR-1: m_rready <= 0, go to Idle.
- rreq timing:
  - The cache drops rreq after the first rack. Because Idle is re-entered only after the final beat, a stale rreq high is never re-accepted for the same burst.
  - A new rreq seen in Idle on the cycle after the last rack is a new request and is accepted with no bubble required.
- Back-to-back bursts: minimum gap of 1 cycle (Idle) between the last R beat and the next AR valid.
- 4 KB rule: bursts are aligned to NTFR*8, which is ≤2 KB, so a burst never crosses a 4 KB boundary. A misaligned base_adr is a software error; no correction is made.
- radr changes outside Idle are ignored.
- A cache invalidate mid-burst is not visible to this block: it completes the AXI burst and keeps emitting rack.
- Reset mid-burst abandons the AXI transaction. The system must reset only when the AXI port is quiescent.
- m_rvalid outside Data is ignored (m_rready=0).

Optional Feature:
- Macro: RDMST_ERRCHK_EN.
- Defined: err is set and held until reset when any accepted beat has m_rresp != 2'b00, or m_rlast disagrees with (count == NTFR-1).
  - Data is still forwarded and the FSM still ends on the count, so no hang occurs.
- Undefined: err tied to 0; m_rresp and m_rlast are unused.

Test Plan:
- Single burst, base=0x1000_0000, radr=0x000A00, arready immediate, rvalid every cycle:
  - exactly one AR with araddr=0x1000_0A00, arlen=63, arsize=3, arburst=1.
  - 64 rack pulses on consecutive cycles, rdata equal to the pattern beats in order.
- Misaligned radr=0x000A37: araddr=base+0x000A00.
- AR back-pressure: arready held 0 for 10 cycles:
  - arvalid stays 1 and araddr stays stable for all 10 cycles.
  - no rack before the AR handshake.
- R gaps: rvalid toggling 1,0,0,1,... over 64 beats:
  - rack count = 64, each rack exactly one cycle after its beat handshake.
  - Idle is reached only after the 64th beat.
- Back-to-back: rreq re-asserted with radr=0x000C00 the cycle after the last rack: second AR issued with no missed or duplicated beats.
- With RDMST_ERRCHK_EN:
  - rresp=2'b10 on beat 5 gives err=1 from the next cycle until xrst.
  - rlast=1 on beat 30 sets err, and the burst still completes after 64 beats.

Source files
------------

// File: rtl/cache_axi_rdmst.sv
// cache_axi_rdmst
// ---------------
// Memory-side read master for the input cache. Each cache refill request
// (rreq/radr) becomes exactly one AXI4 INCR read burst of NTFR 64-bit beats.
// Every returned beat is handed back to the cache as a one-cycle rack strobe,
// with its data on rdata. There is one cache client and at most one burst in
// flight.
//
// Parameters
//   NTFR  beats per burst (power of 2, 2..256); burst size is NTFR*8 bytes
//   AW    AXI address width
//
// Ports
//   clk, xrst          clock, asynchronous active-low reset
//   base_adr           tensor base byte address, sampled when a request is accepted
//   rreq, radr         refill request level and burst start byte offset
//   rack, rdata        beat strobe and beat data back to the cache (registered)
//   m_ar*              AXI read-address channel (len/size/burst are constants)
//   m_r*               AXI read-data channel
//   err                sticky response/last-beat error flag
//
// Build option
//   RDMST_ERRCHK_EN    when defined, err latches on any accepted beat that has
//                      a non-OKAY m_rresp, or whose m_rlast disagrees with the
//                      beat count. When undefined, err is tied low and
//                      m_rresp/m_rlast are ignored.

module cache_axi_rdmst #(
  parameter int NTFR = 64,
  parameter int AW   = 32
) (
  input  logic          clk,
  input  logic          xrst,
  input  logic [AW-1:0] base_adr,
  input  logic          rreq,
  input  logic [23:0]   radr,
  output logic          rack,
  output logic [63:0]   rdata,
  output logic [AW-1:0] m_araddr,
  output logic [7:0]    m_arlen,
  output logic [2:0]    m_arsize,
  output logic [1:0]    m_arburst,
  output logic          m_arvalid,
  input  logic          m_arready,
  input  logic [63:0]   m_rdata,
  input  logic [1:0]    m_rresp,
  input  logic          m_rlast,
  input  logic          m_rvalid,
  output logic          m_rready,
  output logic          err
);

  localparam int OFFW = $clog2(NTFR * 8);
  localparam int CW   = $clog2(NTFR);
  localparam logic [CW-1:0] LASTCOUNT = CW'(NTFR - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state, stateNext;
  logic [CW-1:0] count, countNext;
  logic          arvalidNext, rreadyNext, rackNext;
  logic [63:0]   rdataNext;
  logic [AW-1:0] araddrNext;
  logic [23:0]   radrAligned;
  logic          beat, lastBeat;

  assign m_arlen   = 8'(NTFR - 1);
  assign m_arsize  = 3'b011;
  assign m_arburst = 2'b01;

  // Bursts are always aligned to their own size, so the low offset bits of the
  // cache address are dropped; this also keeps every burst inside one 4 KB page.
  assign radrAligned = {radr[23:OFFW], {OFFW{1'b0}}};

  // m_rready is only high in DATA, so a handshake implies we are in DATA.
  assign beat     = m_rvalid && m_rready;
  assign lastBeat = (count == LASTCOUNT);

  // State register plus all registered outputs.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state     <= IDLE;
      count     <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      m_araddr  <= '0;
      rack      <= 1'b0;
      rdata     <= '0;
    end else begin
      state     <= stateNext;
      count     <= countNext;
      m_arvalid <= arvalidNext;
      m_rready  <= rreadyNext;
      m_araddr  <= araddrNext;
      rack      <= rackNext;
      rdata     <= rdataNext;
    end
  end

  // Next-state and next-output logic. IDLE is re-entered only after the final
  // beat, so an rreq still held high from the burst just finished can never be
  // taken twice; a genuinely new rreq in IDLE is accepted straight away.
  always_comb begin
    stateNext   = state;
    countNext   = count;
    arvalidNext = m_arvalid;
    rreadyNext  = m_rready;
    araddrNext  = m_araddr;
    rackNext    = 1'b0;
    rdataNext   = rdata;
    case (state)
      IDLE: begin
        if (rreq) begin
          araddrNext  = base_adr + AW'(radrAligned);
          arvalidNext = 1'b1;
          countNext   = '0;
          stateNext   = ADDR;
        end
      end
      ADDR: begin
        if (m_arvalid && m_arready) begin
          arvalidNext = 1'b0;
          rreadyNext  = 1'b1;
          stateNext   = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          rackNext  = 1'b1;
          rdataNext = m_rdata;
          countNext = count + 1'b1;
          if (lastBeat) begin
            rreadyNext = 1'b0;
            stateNext  = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef RDMST_ERRCHK_EN
  logic beatBad;
  logic unusedRadrLow;

  assign beatBad       = (m_rresp != 2'b00) || (m_rlast != lastBeat);
  assign unusedRadrLow = ^radr[OFFW-1:0];

  // Sticky error flag; the burst itself still runs to its beat count so a
  // misbehaving slave cannot hang the cache.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      err <= 1'b0;
    end else if (beat && beatBad) begin
      err <= 1'b1;
    end
  end
`else
  logic unusedInputs;

  assign unusedInputs = ^{m_rresp, m_rlast, radr[OFFW-1:0]};
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_cache_axi_rdmst.sv
// Self-checking bench for cache_axi_rdmst. The bench plays the AXI slave from
// a simple address-to-data memory function and tracks expected rack/rdata/err
// from the beats it has handed over.

module tb_cache_axi_rdmst;

  localparam int NTFR  = 64;
  localparam int AW    = 32;
  localparam int BYTES = NTFR * 8;

`ifdef RDMST_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          xrst = 1'b0;
  logic [AW-1:0] base_adr = '0;
  logic          rreq = 1'b0;
  logic [23:0]   radr = '0;
  logic          rack;
  logic [63:0]   rdata;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic          m_arvalid;
  logic          m_arready = 1'b0;
  logic [63:0]   m_rdata = '0;
  logic [1:0]    m_rresp = '0;
  logic          m_rlast = 1'b0;
  logic          m_rvalid = 1'b0;
  logic          m_rready;
  logic          err;

  int          total = 0;
  int          bad = 0;
  int          arCount = 0;
  logic [31:0] seed;
  bit          errExp = 1'b0;
  logic [63:0] lastData = '0;

  cache_axi_rdmst #(.NTFR(NTFR), .AW(AW)) dut (
    .clk(clk), .xrst(xrst), .base_adr(base_adr), .rreq(rreq), .radr(radr),
    .rack(rack), .rdata(rdata), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (xrst && m_arvalid && m_arready) arCount <= arCount + 1;
  end

  function automatic logic [63:0] memWord(input logic [31:0] a);
    return {a ^ seed, (~a) + seed};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyReset;
    @(negedge clk);
    xrst = 1'b0;
    rreq = 1'b0;
    m_rvalid = 1'b0;
    m_arready = 1'b0;
    m_rresp = 2'b00;
    m_rlast = 1'b0;
    step;
    checkOutput("rst_rack", rack, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_arvalid", m_arvalid, 0);
    checkOutput("rst_rready", m_rready, 0);
    checkOutput("rst_araddr", m_araddr, 0);
    checkOutput("rst_err", err, 0);
    step;
    xrst = 1'b1;
    errExp = 1'b0;
    lastData = '0;
  endtask

  // One complete refill. mode 0: rvalid every cycle, 1: 1,0,0 pattern,
  // 2: random gaps. errBeat/lastInj pick a beat for a bad rresp / early rlast.
  task automatic applyStimulus(input logic [31:0] base, input logic [23:0] ra,
                               input int arDelay, input int mode,
                               input int errBeat, input int lastInj);
    logic [31:0] expAddr;
    int          arBefore;
    int          sent;
    int          cyc;
    bit          v;
    logic [63:0] d;
    expAddr  = base + (32'(ra) & ~32'(BYTES - 1));
    arBefore = arCount;
    sent     = 0;
    cyc      = 0;
    base_adr = base;
    radr     = ra;
    rreq     = 1'b1;
    step;
    checkOutput("ar_issue_latency", m_arvalid, 1);
    checkOutput("no_rack_after_burst", rack, 0);
    if (!m_arvalid) begin
      for (int k = 0; k < 20 && !m_arvalid; k++) step;
      if (!m_arvalid) begin
        checkOutput("ar_timeout", 0, 1);
        rreq = 1'b0;
        return;
      end
    end
    checkOutput("araddr", m_araddr, expAddr);
    checkOutput("arlen", m_arlen, NTFR - 1);
    checkOutput("arsize", m_arsize, 3);
    checkOutput("arburst", m_arburst, 1);
    for (int k = 0; k < arDelay; k++) begin
      m_arready = 1'b0;
      m_rvalid  = 1'b1;
      m_rdata   = {$urandom, $urandom};
      radr      = 24'($urandom);
      base_adr  = $urandom;
      step;
      checkOutput("ar_hold_valid", m_arvalid, 1);
      checkOutput("ar_hold_addr", m_araddr, expAddr);
      checkOutput("ar_wait_no_rack", rack, 0);
      checkOutput("ar_wait_rready", m_rready, 0);
    end
    m_rvalid  = 1'b0;
    m_arready = 1'b1;
    step;
    m_arready = 1'b0;
    checkOutput("ar_done_valid", m_arvalid, 0);
    checkOutput("data_rready", m_rready, 1);
    checkOutput("ar_done_no_rack", rack, 0);
    while (sent < NTFR && cyc < 8 * NTFR) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = (cyc % 3 == 0);
      else v = ($urandom_range(0, 2) != 0);
      d        = memWord(expAddr + 32'(sent * 8));
      m_rvalid = v;
      m_rdata  = v ? d : {$urandom, $urandom};
      m_rresp  = (v && sent == errBeat) ? 2'b10 : 2'b00;
      m_rlast  = v && (sent == NTFR - 1 || sent == lastInj);
      radr     = 24'($urandom);
      step;
      cyc++;
      if (v) begin
        if (ERRCHK && (m_rresp != 2'b00 || m_rlast != (sent == NTFR - 1))) errExp = 1'b1;
        lastData = d;
        sent++;
      end
      checkOutput("rack", rack, v);
      checkOutput("rdata", rdata, lastData);
      checkOutput("err", err, errExp);
      checkOutput("data_no_arvalid", m_arvalid, 0);
      checkOutput("rready_until_last", m_rready, sent < NTFR);
      if (sent >= 1) rreq = 1'b0;
    end
    if (sent < NTFR) checkOutput("beat_timeout", sent, NTFR);
    m_rvalid = 1'b0;
    m_rresp  = 2'b00;
    m_rlast  = 1'b0;
    checkOutput("one_ar_per_burst", arCount, arBefore + 1);
  endtask

  initial begin
    seed = $urandom;
    applyReset;
    checkOutput("const_arlen", m_arlen, NTFR - 1);
    checkOutput("const_arsize", m_arsize, 3);
    checkOutput("const_arburst", m_arburst, 1);

    applyStimulus(32'h1000_0000, 24'h000A00, 0, 0, -1, -1);
    applyStimulus(32'h1000_0000, 24'h000C00, 0, 0, -1, -1);
    step;
    step;
    applyStimulus(32'h1000_0000, 24'h000A37, 10, 0, -1, -1);
    step;
    applyStimulus(32'h2000_0000, 24'h123456, 2, 1, -1, -1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus($urandom & ~32'(BYTES - 1), 24'($urandom), $urandom_range(0, 3), 2, -1, -1);
      if (i % 2 == 1) step;
    end

    applyStimulus(32'h3000_0000, 24'h000400, 1, 0, 5, -1);
    step;
    step;
    checkOutput("err_sticky_idle", err, errExp);
    applyReset;
    applyStimulus(32'h3000_0000, 24'h000800, 0, 2, -1, 30);
    step;
    checkOutput("err_rlast_idle", err, errExp);
    applyReset;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
